// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory arbiter: FSM states, grant codes,
// timer width and the contention winner selection helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  typedef enum logic [1:0] {
    GNT_NONE = 2'b00,
    GNT_IF   = 2'b01,
    GNT_D    = 2'b10
  } grant_t;

  localparam int unsigned TIMER_W = 8;

  // pref_d only matters when both sides request in the same cycle
  function automatic grant_t pick_winner(input logic req_if, input logic req_d,
                                         input logic pref_d);
    grant_t w;
    w = GNT_NONE;
    if (req_if && req_d) begin
      w = pref_d ? GNT_D : GNT_IF;
    end else if (req_d) begin
      w = GNT_D;
    end else if (req_if) begin
      w = GNT_IF;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_arb_timer.sv
// BUSY-phase watchdog: counts cycles while enabled, flags the cycle in which
// the TIMEOUT-th consecutive BUSY cycle is reached.
module mem_arb_timer
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

  logic [TIMER_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

  // cnt holds the number of BUSY cycles already completed
  assign expire = en && (cnt == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Two-master (fetch/data) arbiter onto a single memory port with a BUSY timeout.
// Contention policy: MEM_ARB_RR_EN defined -> round-robin, else data has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         if_req,
  input  logic [N-1:0] if_addr,
  output logic [N-1:0] if_rdata,
  output logic         if_ack,
  input  logic         d_req,
  input  logic         d_we,
  input  logic [N-1:0] d_addr,
  input  logic [N-1:0] d_wdata,
  output logic [N-1:0] d_rdata,
  output logic         d_ack,
  output logic         mem_req,
  output logic         mem_we,
  output logic [N-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ready,
  output logic [1:0]   grant,
  output logic         err
);

  arb_state_t state, state_nx;
  grant_t     grant_q, grant_nx;
  logic       capture;
  logic       abort;
  logic       done;
  logic       tmo_expire;
  logic       pref_d;
  logic       any_req;

  assign any_req = if_req || d_req;
  assign done    = capture || abort;
  assign grant   = grant_q;

`ifdef MEM_ARB_RR_EN
  logic rr_ptr_d;

  // Pointer moves to the side that did not win, on every grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_d <= 1'b1;
    end else if ((state == IDLE) && any_req) begin
      rr_ptr_d <= (grant_nx == GNT_IF);
    end
  end

  assign pref_d = rr_ptr_d;
`else
  assign pref_d = 1'b1;
`endif

  mem_arb_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state != BUSY),
    .en     (state == BUSY),
    .expire (tmo_expire)
  );

  always_comb begin
    state_nx = state;
    grant_nx = grant_q;
    capture  = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          state_nx = BUSY;
          grant_nx = pick_winner(if_req, d_req, pref_d);
        end
      end
      BUSY: begin
        // a ready strobe in the expiring cycle still counts as a real transfer
        if (mem_ready) begin
          state_nx = RESP;
          capture  = 1'b1;
        end else if (tmo_expire) begin
          state_nx = RESP;
          abort    = 1'b1;
        end
      end
      RESP: begin
        state_nx = IDLE;
        grant_nx = GNT_NONE;
      end
      default: begin
        state_nx = IDLE;
        grant_nx = GNT_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      grant_q  <= GNT_NONE;
      if_rdata <= '0;
      d_rdata  <= '0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_nx;
      grant_q <= grant_nx;
      if_ack  <= done && (grant_q == GNT_IF);
      d_ack   <= done && (grant_q == GNT_D);
      err     <= abort;
      if (done) begin
        case (grant_q)
          GNT_IF:  if_rdata <= abort ? '0 : mem_rdata;
          GNT_D:   d_rdata  <= (abort || d_we) ? '0 : mem_rdata;
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state == BUSY) begin
      mem_req = 1'b1;
      case (grant_q)
        GNT_IF: begin
          mem_addr = if_addr;
        end
        GNT_D: begin
          mem_we    = d_we;
          mem_addr  = d_addr;
          mem_wdata = d_wdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: table of single-master transactions plus
// directed sequences for reset, reset-in-BUSY, contention and stray mem_ready.
module tb_mem_arbiter;

  localparam int N       = 32;
  localparam int TIMEOUT = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         if_req, d_req, d_we, mem_ready;
  logic [N-1:0] if_addr, d_addr, d_wdata, mem_rdata;
  logic [N-1:0] if_rdata, d_rdata, mem_addr, mem_wdata;
  logic         if_ack, d_ack, mem_req, mem_we, err;
  logic [1:0]   grant;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ack    (if_ack),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_rdata   (d_rdata),
    .d_ack     (d_ack),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .grant     (grant),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ir;
    logic        dr;
    logic        we;
    logic [31:0] ia;
    logic [31:0] da;
    logic [31:0] wd;
    logic [31:0] rd;
    int          ready_at;   // BUSY cycle that sees mem_ready=1, 0 = never
    logic [1:0]  e_gnt;
    int          e_busy;
    int          e_lat;
    int          e_ifack;
    int          e_dack;
    int          e_err;
    logic [31:0] e_rdata;
    logic [31:0] e_maddr;
    logic        e_mwe;
    logic [31:0] e_mwdata;
  } vec_t;

  typedef struct {
    logic [1:0]  gnt;
    int          busy;
    int          lat;
    int          ifack_n;
    int          dack_n;
    int          err_n;
    logic [31:0] rdata;
    logic [31:0] maddr;
    logic        mwe;
    logic [31:0] mwdata;
    logic        stable;
    logic        other_held;
    logic [5:0]  after;
  } obs_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  task automatic run_txn(input vec_t v, output obs_t o);
    logic [31:0] other_before;
    int cyc;
    logic fin;
    o = '{gnt: 2'b00, busy: 0, lat: -1, ifack_n: 0, dack_n: 0, err_n: 0,
          rdata: 32'h0, maddr: 32'h0, mwe: 1'b0, mwdata: 32'h0,
          stable: 1'b1, other_held: 1'b0, after: 6'h3f};
    @(negedge clk);
    if_req = v.ir; if_addr = v.ia;
    d_req = v.dr; d_we = v.we; d_addr = v.da; d_wdata = v.wd;
    mem_ready = 1'b0;
    other_before = v.ir ? d_rdata : if_rdata;
    cyc = 0;
    fin = 1'b0;
    while (!fin && cyc < 64) begin
      @(posedge clk); #1;
      cyc++;
      if (mem_req) begin
        o.busy++;
        if (o.busy == 1) begin
          o.gnt = grant; o.maddr = mem_addr; o.mwe = mem_we; o.mwdata = mem_wdata;
        end else if (grant !== o.gnt || mem_addr !== o.maddr ||
                     mem_we !== o.mwe || mem_wdata !== o.mwdata) begin
          o.stable = 1'b0;
        end
        mem_ready = (o.busy == v.ready_at);
        mem_rdata = mem_ready ? v.rd : 32'h0BAD_0BAD;
      end else begin
        mem_ready = 1'b0;
      end
      if (if_ack) o.ifack_n++;
      if (d_ack)  o.dack_n++;
      if (err)    o.err_n++;
      if (if_ack || d_ack) begin
        o.lat   = cyc;
        o.rdata = v.ir ? if_rdata : d_rdata;
        if_req  = 1'b0;
        d_req   = 1'b0;
        fin     = 1'b1;
      end
    end
    mem_ready = 1'b0;
    if_req = 1'b0;
    d_req  = 1'b0;
    o.other_held = ((v.ir ? d_rdata : if_rdata) === other_before);
    @(posedge clk); #1;
    o.after = {grant, mem_req, if_ack, d_ack, err};
  endtask

  vec_t vecs[8];
  obs_t ob;

  logic [1:0]  gseq[4];
  logic [1:0]  egseq[4];
  int          gidx, ifn, dn;
  logic [31:0] save_if, save_d;

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //            ir    dr    we    ia            da            wd            rd            rdy gnt   busy lat if d err rdata         maddr         mwe   mwdata
    vecs[0] = '{1'b1, 1'b0, 1'b0, 32'h0000_0100, 32'h0,        32'h0,        32'hDEAD_BEEF, 1, 2'b01, 1,  2, 1, 0, 0, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 32'h0};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0200, 32'h1234_5678, 32'hCAFE_F00D, 3, 2'b10, 3,  4, 0, 1, 0, 32'h0,         32'h0000_0200, 1'b1, 32'h1234_5678};
    vecs[2] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0300, 32'h0000_0055, 32'hA5A5_0001, 2, 2'b10, 2,  3, 0, 1, 0, 32'hA5A5_0001, 32'h0000_0300, 1'b0, 32'h0000_0055};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'h0,        32'h0,        32'h0123_4567, 4, 2'b01, 4,  5, 1, 0, 0, 32'h0123_4567, 32'hFFFF_FFFC, 1'b0, 32'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 32'h0,        32'h0000_0400, 32'h0,        32'h9999_9999, 0, 2'b10, 15, 16, 0, 1, 1, 32'h0,         32'h0000_0400, 1'b0, 32'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 32'h0000_0500, 32'h0,        32'h0,        32'h7777_0000, 15, 2'b01, 15, 16, 1, 0, 0, 32'h7777_0000, 32'h0000_0500, 1'b0, 32'h0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 32'h0000_0600, 32'h0,        32'h0,        32'h6666_6666, 0, 2'b01, 15, 16, 1, 0, 1, 32'h0,         32'h0000_0600, 1'b0, 32'h0};
    vecs[7] = '{1'b0, 1'b1, 1'b1, 32'h0,        32'h0000_0700, 32'hFFFF_FFFF, 32'h0000_1111, 1, 2'b10, 1,  2, 0, 1, 0, 32'h0,         32'h0000_0700, 1'b1, 32'hFFFF_FFFF};

    if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ready = 1'b0;
    if_addr = '0; d_addr = '0; d_wdata = '0; mem_rdata = '0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.grant",   32'(grant), 32'h0);
    chk("rst.mem_req", 32'(mem_req), 32'h0);
    chk("rst.mem_we",  32'(mem_we), 32'h0);
    chk("rst.mem_addr", mem_addr, 32'h0);
    chk("rst.mem_wdata", mem_wdata, 32'h0);
    chk("rst.acks_err", 32'({if_ack, d_ack, err}), 32'h0);
    chk("rst.if_rdata", if_rdata, 32'h0);
    chk("rst.d_rdata",  d_rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i], ob);
      chk($sformatf("v%0d.grant", i),   32'(ob.gnt),     32'(vecs[i].e_gnt));
      chk($sformatf("v%0d.busy", i),    ob.busy,         vecs[i].e_busy);
      chk($sformatf("v%0d.latency", i), ob.lat,          vecs[i].e_lat);
      chk($sformatf("v%0d.if_ack_n", i), ob.ifack_n,     vecs[i].e_ifack);
      chk($sformatf("v%0d.d_ack_n", i), ob.dack_n,       vecs[i].e_dack);
      chk($sformatf("v%0d.err_n", i),   ob.err_n,        vecs[i].e_err);
      chk($sformatf("v%0d.rdata", i),   ob.rdata,        vecs[i].e_rdata);
      chk($sformatf("v%0d.mem_addr", i), ob.maddr,       vecs[i].e_maddr);
      chk($sformatf("v%0d.mem_we", i),  32'(ob.mwe),     32'(vecs[i].e_mwe));
      chk($sformatf("v%0d.mem_wdata", i), ob.mwdata,     vecs[i].e_mwdata);
      chk($sformatf("v%0d.busy_stable", i), 32'(ob.stable), 32'h1);
      chk($sformatf("v%0d.other_rdata_held", i), 32'(ob.other_held), 32'h1);
      chk($sformatf("v%0d.idle_after", i), 32'(ob.after), 32'h0);
    end

    // stray mem_ready while idle must not complete anything
    save_if = if_rdata;
    save_d  = d_rdata;
    @(negedge clk);
    mem_ready = 1'b1;
    mem_rdata = 32'h0BAD_F00D;
    repeat (3) begin
      @(posedge clk); #1;
      chk("stray.outputs", 32'({grant, mem_req, if_ack, d_ack, err}), 32'h0);
    end
    chk("stray.if_rdata", if_rdata, save_if);
    chk("stray.d_rdata",  d_rdata,  save_d);
    @(negedge clk);
    mem_ready = 1'b0;

    // reset asserted in the second BUSY cycle aborts without ack, then re-grant
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0800; d_wdata = 32'h0;
    @(posedge clk); #1;
    chk("rstbusy.busy1", 32'({mem_req, grant}), 32'({1'b1, 2'b10}));
    @(posedge clk); #1;
    chk("rstbusy.busy2", 32'({mem_req, grant}), 32'({1'b1, 2'b10}));
    #1 rst_n = 1'b0;
    #1;
    chk("rstbusy.async_mem_req", 32'(mem_req), 32'h0);
    chk("rstbusy.async_grant",   32'(grant), 32'h0);
    chk("rstbusy.async_addr",    mem_addr, 32'h0);
    chk("rstbusy.no_ack",        32'({if_ack, d_ack, err}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rstbusy.regrant", 32'({mem_req, grant}), 32'({1'b1, 2'b10}));
    chk("rstbusy.regrant_addr", mem_addr, 32'h0000_0800);
    mem_ready = 1'b1;
    mem_rdata = 32'h8888_0001;
    @(posedge clk); #1;
    mem_ready = 1'b0;
    d_req = 1'b0;
    chk("rstbusy.ack", 32'({if_ack, d_ack, err}), 32'b010);
    chk("rstbusy.rdata", d_rdata, 32'h8888_0001);
    @(posedge clk); #1;
    chk("rstbusy.idle", 32'({grant, mem_req, d_ack}), 32'h0);

    // contention from a fresh reset, both requests held for four transfers
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    if_req = 1'b1; if_addr = 32'h0000_0A00;
    d_req  = 1'b1; d_we = 1'b0; d_addr = 32'h0000_0B00;
    gidx = 0; ifn = 0; dn = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (mem_req) begin
        if (gidx < 4) gseq[gidx] = grant;
        gidx++;
        mem_ready = 1'b1;
        mem_rdata = 32'h1000 + 32'(c);
      end else begin
        mem_ready = 1'b0;
      end
      if (if_ack) ifn++;
      if (d_ack)  dn++;
    end
    @(negedge clk);
    if_req = 1'b0; d_req = 1'b0; mem_ready = 1'b0;
`ifdef MEM_ARB_RR_EN
    egseq[0] = 2'b10; egseq[1] = 2'b01; egseq[2] = 2'b10; egseq[3] = 2'b01;
    chk("cont.if_acks", ifn, 2);
    chk("cont.d_acks",  dn, 2);
    chk("cont.if_rdata", if_rdata, 32'h0000_1009);
    chk("cont.d_rdata",  d_rdata,  32'h0000_1006);
`else
    egseq[0] = 2'b10; egseq[1] = 2'b10; egseq[2] = 2'b10; egseq[3] = 2'b10;
    chk("cont.if_acks", ifn, 0);
    chk("cont.d_acks",  dn, 4);
    chk("cont.d_rdata", d_rdata, 32'h0000_1009);
`endif
    chk("cont.transfers", gidx, 4);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("cont.grant%0d", k), 32'(gseq[k]), 32'(egseq[k]));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
